// File: rtl/nway_switch_pipe.sv
// nway_switch_pipe: registered N-way select with valid/ready handshake and a wrapping transfer counter.
// Define NWAY_SWITCH_SKID_EN to add a one-entry skid buffer so that in_ready comes from a flop.
module nway_switch_pipe #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 32,
  parameter int SEL_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SEL_WIDTH-1:0]            sel,
  input  logic [(2**SEL_WIDTH)-1:0]       way_mask,
  input  logic [(2**SEL_WIDTH)*BIT_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BIT_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]            out_sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     xfer_count
);
  localparam int WAYS = 2**SEL_WIDTH;
  logic [BIT_WIDTH-1:0] ways [WAYS];
  logic [BIT_WIDTH-1:0] pick;
  logic in_hs, out_hs;
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign ways[g] = in_data[g*BIT_WIDTH +: BIT_WIDTH];
  end
  assign pick   = way_mask[sel] ? ways[sel] : '0;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
`ifdef NWAY_SWITCH_SKID_EN
  logic                 skid_empty;
  logic [BIT_WIDTH-1:0] skid_data;
  logic [SEL_WIDTH-1:0] skid_sel;
  assign in_ready = skid_empty && !rst;
  // A full skid implies a valid output; it refills the output on the next output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      skid_empty <= 1'b1;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else if (!skid_empty) begin
      if (out_ready) begin
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        skid_empty <= 1'b1;
      end
    end else if (in_hs) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= pick;
        out_sel   <= sel;
      end else begin
        skid_data  <= pick;
        skid_sel   <= sel;
        skid_empty <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_data  <= pick;
      out_sel   <= sel;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_count <= '0;
    else if (out_hs) xfer_count <= xfer_count + 16'd1;
  end
endmodule

// File: doc/nway_switch_pipe.md
NWAY_SWITCH_PIPE -- requirements
Module: nway_switch_pipe

Interface
REQ-001 SHALL have parameter UUID, default 0, instance identifier, with no functional effect.
REQ-002 SHALL have parameter NAME, default "", instance label, with no functional effect.
REQ-003 SHALL have parameter BIT_WIDTH, default 32, data width per way (1..64).
REQ-004 SHALL have parameter SEL_WIDTH, default 2, select width (1..4); WAYS = 2**SEL_WIDTH.
REQ-005 SHALL use one clock; reset is asynchronous and active-high, ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 sel  input  SEL_WIDTH  way select, sampled at the input handshake.
REQ-009 way_mask  input  WAYS  per-way enable; bit k=0 means way k yields all-zero data.
REQ-010 in_data  input  WAYS*BIT_WIDTH  flattened ways; way k = bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-011 in_valid  input  1  upstream offers a transfer.
REQ-012 in_ready  output  1  block accepts a transfer.
REQ-013 out_data  output  BIT_WIDTH  selected, registered data.
REQ-014 out_sel  output  SEL_WIDTH  sel value captured with out_data.
REQ-015 out_valid  output  1  out_data/out_sel are valid.
REQ-016 out_ready  input  1  downstream accepts.
REQ-017 xfer_count  output  16  number of completed output handshakes.

Function
REQ-018 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-019 On input handshake the captured data SHALL be way[sel] if way_mask[sel]=1, else zero; out_sel SHALL take sel.
REQ-020 Latency SHALL be 1 cycle: a transfer accepted at edge N presents out_valid=1 after edge N when the output stage is empty.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold unchanged.
REQ-022 Order of transfers SHALL be preserved; no transfer is dropped or duplicated.
REQ-023 Simultaneous input and output handshake on a full output stage SHALL replace the output with the new item (sustained 1 transfer/cycle).
REQ-024 xfer_count SHALL increment by 1 per output handshake and wrap 0xFFFF -> 0x0000.
REQ-025 sel, way_mask and in_data SHALL be don't-care when in_valid=0.
REQ-026 in_ready SHALL be 0 while rst is asserted.

Reset
REQ-027 Asynchronous assertion of rst SHALL immediately force out_valid=0, out_data=0, out_sel=0, xfer_count=0, and the skid entry (if present) empty.
REQ-028 rst asserted mid-transfer SHALL discard all held items; no output handshake is reported after release until a new input is accepted.
REQ-029 The first input handshake SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro NWAY_SWITCH_SKID_EN SHALL select the output buffering.
REQ-031 Without NWAY_SWITCH_SKID_EN: single output register; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-032 With NWAY_SWITCH_SKID_EN: added one-entry skid buffer; in_ready SHALL be a flop output equal to "skid empty", with no combinational path from out_ready; an input accepted while the output is stalled goes to the skid entry and moves to the output on the next output handshake.
REQ-033 Both builds SHALL be functionally identical at the transaction level (same data, order and count).

Verification (BIT_WIDTH=32, SEL_WIDTH=2)
REQ-034 ways = {0x44444444,0x33333333,0x22222222,0x11111111}, way_mask=4'hF, sel=2, one beat, out_ready=1 -> next cycle out_data=0x33333333, out_sel=2, out_valid=1; xfer_count=1 after the handshake.
REQ-035 way_mask=4'b1011, sel=2 -> out_data=0x00000000, out_sel=2.
REQ-036 out_ready=0 for 5 cycles with in_valid=1 and sel=0..3 -> out_data is held at the first item; no-skid build accepts 1 item, skid build accepts 2; after out_ready=1, items emerge in order with no loss.
REQ-037 Continuous in_valid=1 and out_ready=1 for 100 beats -> 100 outputs on consecutive cycles, xfer_count=100.
REQ-038 Preload xfer_count to 0xFFFF via 65535 transfers, then one more transfer -> xfer_count=0x0000.
REQ-039 Assert rst between edges while out_valid=1 -> out_valid=0 and out_data=0 immediately, before the next edge; in_ready=0 until release.
